// File: rtl/lsu_ctrl_pkg.sv
// Shared types and helpers for the load/store sequencer: access sizes,
// controller states and the size/alignment decode used when a request lands.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } mem_op_sz_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] mem_op_nbytes(input mem_op_sz_e size);
    case (size)
      BYTE:    return 3'd1;
      HWORD:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A halfword needs an even address, a word needs a multiple of four.
  function automatic logic mem_op_misaligned(input mem_op_sz_e size,
                                             input logic [1:0] addr_lo);
    return ((size == HWORD) && addr_lo[0]) ||
           ((size == WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake with the core plus the data-memory bus.
// The controller uses the slave view; the core/memory side uses master.
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  mem_op_sz_e  req_size;
  logic        req_unsigned;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  mem_op_sz_e  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_data_ready;
  logic        mem_write_ready;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  rsp_ready, mem_rdata, mem_data_ready, mem_write_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_re, mem_addr, mem_wdata, mem_size
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output rsp_ready, mem_rdata, mem_data_ready, mem_write_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_re, mem_addr, mem_wdata, mem_size
  );

endinterface

// File: rtl/lsu_rdata_fmt.sv
// Sign/zero extension of an LSB-aligned load word according to access size.
// Kept standalone so the instruction-fetch path can share it.
module lsu_rdata_fmt
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  mem_op_sz_e  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  // Extend the low byte/halfword; full words pass straight through.
  always_comb begin
    data = word;
    case (size)
      BYTE:    data = {{24{!is_unsigned & word[7]}},  word[7:0]};
      HWORD:   data = {{16{!is_unsigned & word[15]}}, word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: takes one core request at a time, bounds- and
// alignment-checks it, splits misaligned accesses into byte beats and
// returns a single formatted response with an error flag.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned MemoryBytesSize = 16,
  parameter bit          AllowMisaligned = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  lsu_ctrl_if.slave   bus
);

  lsu_state_e  state_q, state_d;

  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic        split_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  mem_op_sz_e  size_q;
  logic [2:0]  nbeats_q;
  logic [1:0]  beat_q;
  logic [31:0] asm_q;

  logic [2:0]  req_nbytes;
  logic        req_mis;
  logic [32:0] req_end;
  logic        req_err;
  logic        beat_done;
  logic        last_beat;
  logic [31:0] beat_addr;
  logic [31:0] fmt_data;

  // Request decode: range is checked as addr + nbytes > size in 33 bits so
  // addresses near 2^32 cannot wrap into the valid window.
  always_comb begin
    req_nbytes = mem_op_nbytes(bus.req_size);
    req_mis    = mem_op_misaligned(bus.req_size, bus.req_addr[1:0]);
    req_end    = {1'b0, bus.req_addr} + {30'd0, req_nbytes};
    req_err    = (req_end > 33'(MemoryBytesSize)) ||
                 (req_mis && !AllowMisaligned);
    beat_done  = we_q ? bus.mem_write_ready : bus.mem_data_ready;
    last_beat  = ({1'b0, beat_q} == (nbeats_q - 3'd1));
    beat_addr  = addr_q + {30'd0, beat_q};
  end

  lsu_rdata_fmt u_fmt (
    .word        (asm_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (fmt_data)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and bus outputs; memory enables are held for the whole beat.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'd0;
    bus.rsp_err   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_size  = BYTE;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_we = we_q;
        bus.mem_re = !we_q;
        if (split_q) begin
          bus.mem_addr  = beat_addr;
          bus.mem_size  = BYTE;
          bus.mem_wdata = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
        end else begin
          bus.mem_addr  = addr_q;
          bus.mem_size  = size_q;
          bus.mem_wdata = wdata_q;
        end
        if (beat_done && last_beat) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = (we_q || err_q) ? 32'd0 : fmt_data;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the request only when accepted in IDLE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      split_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      size_q   <= BYTE;
      nbeats_q <= 3'd0;
    end else if (state_q == IDLE && bus.req_valid) begin
      we_q     <= bus.req_we;
      uns_q    <= bus.req_unsigned;
      err_q    <= req_err;
      split_q  <= req_mis;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
      size_q   <= bus.req_size;
      nbeats_q <= req_mis ? req_nbytes : 3'd1;
    end
  end

  // Beat counter and load-data assembly.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      beat_q <= 2'd0;
      asm_q  <= 32'd0;
    end else if (state_q == IDLE) begin
      beat_q <= 2'd0;
      if (bus.req_valid) asm_q <= 32'd0;
    end else if (state_q == ACCESS && beat_done) begin
      if (!we_q) begin
        if (split_q) asm_q[{beat_q, 3'b000} +: 8] <= bus.mem_rdata[7:0];
        else         asm_q <= bus.mem_rdata;
      end
      if (!last_beat) beat_q <= beat_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of requests against a 16-byte
// memory model, plus hand-written sequences for the no-misalign variant and
// reset in the middle of a split store.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lsu_ctrl_if bus0 ();
  lsu_ctrl_if bus1 ();

  lsu_ctrl #(.MemoryBytesSize(16), .AllowMisaligned(1'b1)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus0)
  );

  lsu_ctrl #(.MemoryBytesSize(16), .AllowMisaligned(1'b0)) dut_na (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus1)
  );

  // 16-byte memory: combinational read, write on the clock edge when taken.
  logic [7:0] mem [16] = '{default: 8'h00};
  logic [3:0] ma;
  always_comb begin
    ma = bus0.mem_addr[3:0];
    bus0.mem_rdata = {mem[ma + 4'd3], mem[ma + 4'd2], mem[ma + 4'd1], mem[ma]};
    if (bus0.mem_size == BYTE)       bus0.mem_rdata = {24'd0, mem[ma]};
    else if (bus0.mem_size == HWORD) bus0.mem_rdata = {16'd0, mem[ma + 4'd1], mem[ma]};
  end
  always @(posedge clk) begin
    if (bus0.mem_we && bus0.mem_write_ready) begin
      mem[ma] <= bus0.mem_wdata[7:0];
      if (bus0.mem_size != BYTE) mem[ma + 4'd1] <= bus0.mem_wdata[15:8];
      if (bus0.mem_size == WORD) begin
        mem[ma + 4'd2] <= bus0.mem_wdata[23:16];
        mem[ma + 4'd3] <= bus0.mem_wdata[31:24];
      end
    end
  end

  assign bus1.mem_rdata       = 32'h12345678;
  assign bus1.mem_data_ready  = 1'b1;
  assign bus1.mem_write_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_op_sz_e  size;
    logic        uns;
    int          stall;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t v[22];

  // Issue one request on bus0, measure latency and enable cycles, check response.
  task automatic do_req(input vec_t t, input string nm);
    int  lat;
    int  en;
    bit  got;
    @(negedge clk);
    chk({nm, "_req_ready"}, 32'(bus0.req_ready), 32'd1);
    bus0.req_we       = t.we;
    bus0.req_addr     = t.addr;
    bus0.req_wdata    = t.wdata;
    bus0.req_size     = t.size;
    bus0.req_unsigned = t.uns;
    bus0.req_valid    = 1'b1;
    bus0.rsp_ready    = (t.hold == 0);
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    lat = 0;
    en  = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus0.rsp_valid) got = 1'b1;
      else begin
        bus0.mem_data_ready  = (lat > t.stall);
        bus0.mem_write_ready = (lat > t.stall);
        en += int'(bus0.mem_re | bus0.mem_we);
        chk({nm, "_busy_ready"}, 32'(bus0.req_ready), 32'd0);
      end
    end
    chk({nm, "_lat"},   32'(lat),            32'(t.exp_lat));
    chk({nm, "_en"},    32'(en),             32'(t.exp_en));
    chk({nm, "_err"},   32'(bus0.rsp_err),   32'(t.exp_err));
    chk({nm, "_rdata"}, bus0.rsp_rdata,      t.exp_rdata);
    for (int h = 0; h < t.hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(bus0.rsp_valid), 32'd1);
      chk({nm, "_hold_rdata"}, bus0.rsp_rdata,      t.exp_rdata);
    end
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_rsp_drop"}, 32'(bus0.rsp_valid), 32'd0);
    bus0.mem_data_ready  = 1'b1;
    bus0.mem_write_ready = 1'b1;
  endtask

  initial begin
    vec_t t;
    // we addr wdata size uns stall hold exp_rdata err lat en
    v[0]  = '{1'b1, 32'd4,  32'hDEADBEEF, WORD,  1'b0, 0, 0, 32'h00000000, 1'b0, 2, 1};
    v[1]  = '{1'b0, 32'd4,  32'h0,        WORD,  1'b0, 0, 0, 32'hDEADBEEF, 1'b0, 2, 1};
    v[2]  = '{1'b0, 32'd7,  32'h0,        BYTE,  1'b0, 0, 0, 32'hFFFFFFDE, 1'b0, 2, 1};
    v[3]  = '{1'b0, 32'd7,  32'h0,        BYTE,  1'b1, 0, 0, 32'h000000DE, 1'b0, 2, 1};
    v[4]  = '{1'b1, 32'd9,  32'h00008001, HWORD, 1'b0, 0, 0, 32'h00000000, 1'b0, 3, 2};
    v[5]  = '{1'b0, 32'd9,  32'h0,        HWORD, 1'b0, 0, 0, 32'hFFFF8001, 1'b0, 3, 2};
    v[6]  = '{1'b0, 32'd9,  32'h0,        HWORD, 1'b1, 0, 0, 32'h00008001, 1'b0, 3, 2};
    v[7]  = '{1'b0, 32'd13, 32'h0,        WORD,  1'b0, 0, 0, 32'h00000000, 1'b1, 1, 0};
    v[8]  = '{1'b0, 32'd2,  32'h0,        WORD,  1'b0, 0, 0, 32'hBEEF0000, 1'b0, 5, 4};
    v[9]  = '{1'b1, 32'd15, 32'hFFFFFF5A, BYTE,  1'b0, 0, 0, 32'h00000000, 1'b0, 2, 1};
    v[10] = '{1'b0, 32'd15, 32'h0,        BYTE,  1'b1, 0, 0, 32'h0000005A, 1'b0, 2, 1};
    v[11] = '{1'b0, 32'd15, 32'h0,        BYTE,  1'b0, 0, 0, 32'h0000005A, 1'b0, 2, 1};
    v[12] = '{1'b0, 32'd15, 32'h0,        HWORD, 1'b0, 0, 0, 32'h00000000, 1'b1, 1, 0};
    v[13] = '{1'b1, 32'hFFFFFFFF, 32'h1,  BYTE,  1'b0, 0, 0, 32'h00000000, 1'b1, 1, 0};
    v[14] = '{1'b1, 32'd12, 32'h11223344, WORD,  1'b0, 0, 0, 32'h00000000, 1'b0, 2, 1};
    v[15] = '{1'b0, 32'd14, 32'h0,        HWORD, 1'b0, 0, 0, 32'h00001122, 1'b0, 2, 1};
    v[16] = '{1'b0, 32'd12, 32'h0,        HWORD, 1'b0, 3, 0, 32'h00003344, 1'b0, 5, 4};
    v[17] = '{1'b1, 32'd1,  32'hA1B2C3D4, WORD,  1'b0, 0, 0, 32'h00000000, 1'b0, 5, 4};
    v[18] = '{1'b0, 32'd0,  32'h0,        WORD,  1'b0, 0, 2, 32'hB2C3D400, 1'b0, 2, 1};
    v[19] = '{1'b0, 32'd3,  32'h0,        HWORD, 1'b0, 2, 0, 32'hFFFFA1B2, 1'b0, 5, 4};
    v[20] = '{1'b1, 32'd16, 32'h77,       BYTE,  1'b0, 0, 0, 32'h00000000, 1'b1, 1, 0};
    v[21] = '{1'b0, 32'd12, 32'h0,        WORD,  1'b0, 0, 0, 32'h11223344, 1'b0, 2, 1};

    rstn = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 32'd0;
    bus0.req_wdata = 32'd0; bus0.req_size = BYTE; bus0.req_unsigned = 1'b0;
    bus0.rsp_ready = 1'b1; bus0.mem_data_ready = 1'b1; bus0.mem_write_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 32'd0;
    bus1.req_wdata = 32'd0; bus1.req_size = BYTE; bus1.req_unsigned = 1'b0;
    bus1.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus0.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst_mem_en",    32'({bus0.mem_we, bus0.mem_re}), 32'd0);
    chk("rst_rdata",     bus0.rsp_rdata, 32'd0);
    chk("rst_err",       32'(bus0.rsp_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 22; i++) do_req(v[i], $sformatf("v%0d", i));

    // No-misalign variant: misaligned word is rejected without a memory read.
    @(negedge clk);
    bus1.req_we = 1'b0; bus1.req_addr = 32'd2; bus1.req_size = WORD;
    bus1.req_unsigned = 1'b0; bus1.req_valid = 1'b1;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
    @(negedge clk);
    chk("na_mis_valid", 32'(bus1.rsp_valid), 32'd1);
    chk("na_mis_err",   32'(bus1.rsp_err),   32'd1);
    chk("na_mis_rdata", bus1.rsp_rdata,      32'd0);
    chk("na_mis_re",    32'(bus1.mem_re),    32'd0);
    @(posedge clk);
    // Same variant still performs aligned loads.
    @(negedge clk);
    bus1.req_addr = 32'd4; bus1.req_valid = 1'b1;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
    @(negedge clk);
    chk("na_al_re",     32'(bus1.mem_re),    32'd1);
    chk("na_al_c1",     32'(bus1.rsp_valid), 32'd0);
    @(negedge clk);
    chk("na_al_valid",  32'(bus1.rsp_valid), 32'd1);
    chk("na_al_err",    32'(bus1.rsp_err),   32'd0);
    chk("na_al_rdata",  bus1.rsp_rdata,      32'h12345678);
    @(posedge clk);

    // Reset in the middle of a split store: beat 0 stays written.
    @(negedge clk);
    bus0.req_we = 1'b1; bus0.req_addr = 32'd5; bus0.req_wdata = 32'h00007766;
    bus0.req_size = HWORD; bus0.req_valid = 1'b1;
    bus0.mem_write_ready = 1'b0;
    @(posedge clk);
    #1 bus0.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rm_b0_addr", bus0.mem_addr, 32'd5);
    chk("rm_b0_we",   32'(bus0.mem_we), 32'd1);
    chk("rm_b0_data", bus0.mem_wdata, 32'h00000066);
    bus0.mem_write_ready = 1'b1;
    @(posedge clk);
    #1 bus0.mem_write_ready = 1'b0;
    @(negedge clk);
    chk("rm_b1_addr", bus0.mem_addr, 32'd6);
    chk("rm_b1_size", 32'(bus0.mem_size), 32'(BYTE));
    chk("rm_b1_data", bus0.mem_wdata, 32'h00000077);
    chk("rm_mem5",    32'(mem[5]), 32'h66);
    #2 rstn = 1'b0;
    #1;
    chk("rm_rst_ready", 32'(bus0.req_ready), 32'd1);
    chk("rm_rst_we",    32'(bus0.mem_we),    32'd0);
    chk("rm_rst_addr",  bus0.mem_addr,       32'd0);
    chk("rm_rst_wdata", bus0.mem_wdata,      32'd0);
    chk("rm_rst_valid", 32'(bus0.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    bus0.mem_write_ready = 1'b1;
    chk("rm_mem6", 32'(mem[6]), 32'hAD);
    t = '{1'b0, 32'd5, 32'h0, HWORD, 1'b1, 0, 0, 32'h0000AD66, 1'b0, 3, 2};
    do_req(t, "rm_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
